// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared types and constants for the CPU run controller:
//                run-state enumeration, phase bus codes and default counter
//                width.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    // Run-state of the controller.
    typedef enum logic [1:0] {
        RUN_IDLE   = 2'd0,
        RUN_ACTIVE = 2'd1,
        RUN_HALTED = 2'd2
    } run_state_t;

    // Phase bus codes: 0 is idle, 1..5 are the instruction phases.
    localparam logic [2:0] PHASE_IDLE  = 3'd0;
    localparam logic [2:0] PHASE_FIRST = 3'd1;
    localparam logic [2:0] PHASE_LAST  = 3'd5;

    // Default width of the cycle and retired-instruction counters.
    localparam int CNT_W_DEFAULT = 32;

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/exec_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : exec_sync_edge
//  Description : Multi-flop synchroniser for an asynchronous level input,
//                followed by a rising-edge detector producing a one-cycle
//                pulse.
//  Ports       : clk       in  system clock
//                rst       in  synchronous active-high reset
//                async_in  in  asynchronous level input
//                pulse_out out one-cycle pulse on each synchronised rise
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse_out
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // High for one cycle after the synchronised level goes 0 -> 1; a held
    // input therefore yields a single pulse.
    assign pulse_out = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule : exec_sync_edge
`default_nettype wire

// File: rtl/run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : run_controller
//  Description : Sequences the datapath through instruction phases 1..5 and
//                owns run / pause / single-step / breakpoint / halt control,
//                plus active-cycle and retired-instruction counters.
//  Ports       : clk, rst          clock, synchronous active-high reset
//                exec              raw run/step/pause request (async level)
//                step_mode         1 = each start runs one instruction
//                hlt               halt indication from control
//                bp_en, bp_addr    breakpoint enable and PC
//                pc                current program counter
//                phase             0 = idle, 1..5 = instruction phase
//                running           phase != 0
//                halted            sticky halt status
//                bp_hit            stopped on breakpoint
//                cycle_count       cycles spent with phase != 0
//                instr_count       retired instructions
//  Revision    : 1.0 - initial release
// ============================================================================
module run_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exec,
    input  logic             step_mode,
    input  logic             hlt,
    input  logic             bp_en,
    input  logic [15:0]      bp_addr,
    input  logic [15:0]      pc,
    output logic [2:0]       phase,
    output logic             running,
    output logic             halted,
    output logic             bp_hit,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    logic             w_exec_pulse;

    run_state_t       r_state,        w_state_nxt;
    logic [2:0]       r_phase,        w_phase_nxt;
    logic             r_halted,       w_halted_nxt;
    logic             r_bp_hit,       w_bp_hit_nxt;
    logic             r_skip_bp,      w_skip_bp_nxt;
    logic             r_step_latched, w_step_latched_nxt;
    logic             r_halt_pend,    w_halt_pend_nxt;
    logic             r_pause_pend,   w_pause_pend_nxt;
    logic             r_bp_pend,      w_bp_pend_nxt;
    logic [CNT_W-1:0] r_cycle_cnt,    w_cycle_cnt_nxt;
    logic [CNT_W-1:0] r_instr_cnt,    w_instr_cnt_nxt;

    // Pending conditions including this cycle's events, so that an hlt or
    // exec pulse coinciding with the phase-5 edge still takes part in the
    // stop decision made on that edge.
    logic w_halt_now;
    logic w_pause_now;
    logic w_bp_now;

    exec_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_exec_sync (
        .clk       (clk),
        .rst       (rst),
        .async_in  (exec),
        .pulse_out (w_exec_pulse)
    );

    assign w_halt_now  = r_halt_pend | hlt;
    assign w_pause_now = r_pause_pend | (w_exec_pulse & ~r_step_latched);
    // The breakpoint is only compared at the phase-1 edge; the first
    // instruction after a start is exempt so a resume from a breakpoint
    // does not re-trap on the same PC.
    assign w_bp_now    = r_bp_pend |
                         ((r_phase == PHASE_FIRST) & bp_en &
                          (pc == bp_addr) & ~r_skip_bp);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RUN_IDLE;
            r_phase        <= PHASE_IDLE;
            r_halted       <= 1'b0;
            r_bp_hit       <= 1'b0;
            r_skip_bp      <= 1'b0;
            r_step_latched <= 1'b0;
            r_halt_pend    <= 1'b0;
            r_pause_pend   <= 1'b0;
            r_bp_pend      <= 1'b0;
            r_cycle_cnt    <= '0;
            r_instr_cnt    <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_phase        <= w_phase_nxt;
            r_halted       <= w_halted_nxt;
            r_bp_hit       <= w_bp_hit_nxt;
            r_skip_bp      <= w_skip_bp_nxt;
            r_step_latched <= w_step_latched_nxt;
            r_halt_pend    <= w_halt_pend_nxt;
            r_pause_pend   <= w_pause_pend_nxt;
            r_bp_pend      <= w_bp_pend_nxt;
            r_cycle_cnt    <= w_cycle_cnt_nxt;
            r_instr_cnt    <= w_instr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_phase_nxt        = r_phase;
        w_halted_nxt       = r_halted;
        w_bp_hit_nxt       = r_bp_hit;
        w_skip_bp_nxt      = r_skip_bp;
        w_step_latched_nxt = r_step_latched;
        w_halt_pend_nxt    = r_halt_pend;
        w_pause_pend_nxt   = r_pause_pend;
        w_bp_pend_nxt      = r_bp_pend;
        w_cycle_cnt_nxt    = r_cycle_cnt;
        w_instr_cnt_nxt    = r_instr_cnt;

        case (r_state)
            RUN_IDLE: begin
                if (w_exec_pulse) begin
                    w_state_nxt        = RUN_ACTIVE;
                    w_phase_nxt        = PHASE_FIRST;
                    w_bp_hit_nxt       = 1'b0;
                    w_skip_bp_nxt      = 1'b1;
                    w_step_latched_nxt = step_mode;
                end
            end

            RUN_ACTIVE: begin
                w_cycle_cnt_nxt  = r_cycle_cnt + CNT_W'(1);
                w_halt_pend_nxt  = w_halt_now;
                w_pause_pend_nxt = w_pause_now;
                w_bp_pend_nxt    = w_bp_now;
                if (r_phase == PHASE_FIRST) begin
                    w_skip_bp_nxt = 1'b0;
                end

                if (r_phase == PHASE_LAST) begin
                    w_instr_cnt_nxt  = r_instr_cnt + CNT_W'(1);
                    w_halt_pend_nxt  = 1'b0;
                    w_pause_pend_nxt = 1'b0;
                    w_bp_pend_nxt    = 1'b0;
                    if (w_halt_now) begin
                        w_state_nxt  = RUN_HALTED;
                        w_phase_nxt  = PHASE_IDLE;
                        w_halted_nxt = 1'b1;
                        if (w_bp_now) begin
                            w_bp_hit_nxt = 1'b1;
                        end
                    end else if (w_bp_now) begin
                        w_state_nxt  = RUN_IDLE;
                        w_phase_nxt  = PHASE_IDLE;
                        w_bp_hit_nxt = 1'b1;
                    end else if (w_pause_now || r_step_latched) begin
                        w_state_nxt = RUN_IDLE;
                        w_phase_nxt = PHASE_IDLE;
                    end else begin
                        w_phase_nxt = PHASE_FIRST;
                    end
                end else begin
                    w_phase_nxt = r_phase + 3'd1;
                end
            end

            RUN_HALTED: begin
                // Only reset leaves this state; everything holds.
            end

            default: begin
                w_state_nxt = RUN_IDLE;
                w_phase_nxt = PHASE_IDLE;
            end
        endcase
    end

    assign phase       = r_phase;
    assign running     = (r_phase != PHASE_IDLE);
    assign halted      = r_halted;
    assign bp_hit      = r_bp_hit;
    assign cycle_count = r_cycle_cnt;
    assign instr_count = r_instr_cnt;

endmodule : run_controller
`default_nettype wire
